// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, ext/ALU/wb selects, cond and class codes.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package ctrl_pkg;

  // One state per phase of an instruction; exactly eight, so three bits cover them all.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC_DP   = 3'd2,
    ST_WB_ALU    = 3'd3,
    ST_EXEC_ADDR = 3'd4,
    ST_MEM       = 3'd5,
    ST_WB_MEM    = 3'd6,
    ST_BRANCH    = 3'd7
  } state_e;

  // Immediate-extension selects driven to the datapath.
  localparam logic [1:0] EXT_IMM8  = 2'b00;
  localparam logic [1:0] EXT_IMM12 = 2'b01;
  localparam logic [1:0] EXT_BR24  = 2'b10;
  localparam logic [1:0] EXT_ZERO  = 2'b11;

  // ALU opcodes the controller issues itself (address generation).
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  // Supported condition codes; anything else never passes.
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Instruction classes, instr[27:26].
  localparam logic [1:0] CLASS_DP  = 2'b00;
  localparam logic [1:0] CLASS_MEM = 2'b01;
  localparam logic [1:0] CLASS_BR  = 2'b10;
  localparam logic [1:0] CLASS_ILL = 2'b11;

  // Register-file write-back source selects.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // PC next-value selects.
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;

  // Extension op implied by the instruction class; a register-operand DP op gets ZERO.
  function automatic logic [1:0] ext_op_for(input logic [1:0] cls, input logic imm_bit);
    logic [1:0] op;
    op = EXT_ZERO;
    case (cls)
      CLASS_DP:  op = imm_bit ? EXT_IMM8 : EXT_ZERO;
      CLASS_MEM: op = EXT_IMM12;
      CLASS_BR:  op = EXT_BR24;
      default:   op = EXT_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory side.
// Latency: none (wires only).
// Backpressure: mem_ready is the only stall input; mem_req is held until it is seen.
interface multicycle_ctrl_if;

  logic [31:0] instr;
  logic [3:0]  flags;
  logic        mem_ready;

  logic [1:0]  ext_op;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic        flags_we;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        retire;
  logic        illegal;
  logic        bus_err;

  // Controller side: consumes IR/flags/ready, drives every control strobe.
  modport master (
    input  instr, flags, mem_ready,
    output ext_op, ir_we, pc_we, pc_src, alu_src_b, alu_op, flags_we,
           reg_we, wb_sel, mem_req, mem_we, mem_addr_sel, retire, illegal, bus_err
  );

  // Datapath/memory side: mirror image of the controller.
  modport slave (
    output instr, flags, mem_ready,
    input  ext_op, ir_we, pc_we, pc_src, alu_src_b, alu_op, flags_we,
           reg_we, wb_sel, mem_req, mem_we, mem_addr_sel, retire, illegal, bus_err
  );

endinterface

// File: rtl/multicycle_ctrl_cond_check.sv
// Condition-code evaluation: (cond, NZCV) -> pass.
// Latency: combinational.
// Backpressure: none.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n_flag;
  logic z_flag;
  logic v_flag;
  logic unused_carry;

  assign n_flag = flags_i[3];
  assign z_flag = flags_i[2];
  assign v_flag = flags_i[0];
  // Carry is not consulted by any supported condition.
  assign unused_carry = flags_i[1];

  // Unsupported encodings fall to the default and fail.
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z_flag;
      COND_NE: pass_o = ~z_flag;
      COND_GE: pass_o = (n_flag == v_flag);
      COND_LT: pass_o = (n_flag != v_flag);
      COND_GT: pass_o = ~z_flag && (n_flag == v_flag);
      COND_LE: pass_o = z_flag || (n_flag != v_flag);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback sequencing with bounded memory waits.
// Latency: DP 4 cycles (compare 3), load 5, store 4, branch 3, annulled 2, plus memory wait cycles.
// Backpressure: FETCH/MEM hold mem_req until mem_ready; after 2**TIMEOUT_W-1 idle waits bus_err fires.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [TIMEOUT_W-1:0] WAIT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WAIT_MAX = {TIMEOUT_W{1'b1}};

  state_e               state_q;
  state_e               state_d;
  logic [TIMEOUT_W-1:0] wait_q;
  logic [TIMEOUT_W-1:0] wait_d;

  logic [1:0] instr_class;
  logic       imm_bit;
  logic [3:0] opc;
  logic       up_bit;
  logic       load_bit;
  logic       link_bit;
  logic       cond_pass;
  logic       mem_phase;
  logic       waiting;
  logic       timeout;
  logic       unused_instr_bits;

  assign instr_class = bus.instr[27:26];
  assign imm_bit     = bus.instr[25];
  assign opc         = bus.instr[24:21];
  assign link_bit    = bus.instr[24];
  assign up_bit      = bus.instr[23];
  assign load_bit    = bus.instr[20];
  // Register/immediate fields belong to the datapath, not to sequencing.
  assign unused_instr_bits = ^bus.instr[19:0];

  cond_check u_cond_check (
    .cond_i  (bus.instr[31:28]),
    .flags_i (bus.flags),
    .pass_o  (cond_pass)
  );

  // Only FETCH and MEM talk to memory; mem_ready elsewhere is ignored.
  assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign waiting   = mem_phase && !bus.mem_ready;
  // A ready on the same cycle as the limit takes priority, since waiting requires !mem_ready.
  assign timeout   = waiting && (wait_q == WAIT_MAX);

  // State register and wait counter; reset restarts at FETCH and abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Wait counter advances only while stalled; ready, timeout or leaving the state all clear it.
  always_comb begin
    wait_d = '0;
    if (waiting && !timeout) begin
      wait_d = wait_q + WAIT_ONE;
    end
  end

  // Next-state and control decode; all strobes stay low while reset is asserted.
  always_comb begin
    state_d          = state_q;
    bus.ext_op       = EXT_ZERO;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_src       = PC_PLUS4;
    bus.alu_src_b    = 1'b0;
    bus.alu_op       = ALU_ADD;
    bus.flags_we     = 1'b0;
    bus.reg_we       = 1'b0;
    bus.wb_sel       = WB_ALU;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.retire       = 1'b0;
    bus.illegal      = 1'b0;
    bus.bus_err      = 1'b0;

    if (!rst) begin
      // IR is still being loaded during FETCH, so the extension op is only meaningful afterwards.
      if (state_q != ST_FETCH) begin
        bus.ext_op = ext_op_for(instr_class, imm_bit);
      end

      case (state_q)
        ST_FETCH: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b0;
          if (bus.mem_ready) begin
            bus.ir_we  = 1'b1;
            bus.pc_we  = 1'b1;
            bus.pc_src = PC_PLUS4;
            state_d    = ST_DECODE;
          end else if (timeout) begin
            // Refetch the same PC: nothing was committed.
            bus.bus_err = 1'b1;
            state_d     = ST_FETCH;
          end
        end

        ST_DECODE: begin
          if (!cond_pass) begin
            bus.retire = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            case (instr_class)
              CLASS_DP:  state_d = ST_EXEC_DP;
              CLASS_MEM: state_d = ST_EXEC_ADDR;
              CLASS_BR:  state_d = ST_BRANCH;
              default: begin
                bus.illegal = 1'b1;
                bus.retire  = 1'b1;
                state_d     = ST_FETCH;
              end
            endcase
          end
        end

        ST_EXEC_DP: begin
          bus.alu_src_b = imm_bit;
          bus.alu_op    = opc;
          bus.flags_we  = load_bit;
          // Compare/test ops only set flags, so they retire without a write-back cycle.
          if (opc[3:2] == 2'b10) begin
            bus.retire = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB_ALU;
          end
        end

        ST_WB_ALU: begin
          bus.reg_we = 1'b1;
          bus.wb_sel = WB_ALU;
          bus.retire = 1'b1;
          state_d    = ST_FETCH;
        end

        ST_EXEC_ADDR: begin
          bus.alu_src_b = 1'b1;
          bus.alu_op    = up_bit ? ALU_ADD : ALU_SUB;
          state_d       = ST_MEM;
        end

        ST_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we       = ~load_bit;
          if (bus.mem_ready) begin
            if (load_bit) begin
              state_d = ST_WB_MEM;
            end else begin
              bus.retire = 1'b1;
              state_d    = ST_FETCH;
            end
          end else if (timeout) begin
            // Drop the store qualifier so a late memory cannot complete a write.
            bus.mem_we  = 1'b0;
            bus.bus_err = 1'b1;
            state_d     = ST_FETCH;
          end
        end

        ST_WB_MEM: begin
          bus.reg_we = 1'b1;
          bus.wb_sel = WB_MEM;
          bus.retire = 1'b1;
          state_d    = ST_FETCH;
        end

        ST_BRANCH: begin
          bus.pc_we  = 1'b1;
          bus.pc_src = PC_BRANCH;
          bus.retire = 1'b1;
          // Link writes the old PC into the register file alongside the PC update.
          if (link_bit) begin
            bus.reg_we = 1'b1;
            bus.wb_sel = WB_PC;
          end
          state_d = ST_FETCH;
        end

        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: reset, DP/compare, load with waits, branches, timeout, illegal.
// Latency: checks each cycle of every instruction against hand-computed strobes.
// Backpressure: mem_ready is driven per cycle by each scenario.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  wire [8:0] strobes = {bus.ir_we, bus.pc_we, bus.flags_we, bus.reg_we, bus.mem_req,
                        bus.mem_we, bus.retire, bus.illegal, bus.bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.instr = 32'h0; bus.flags = 4'h0; bus.mem_ready = 1'b1;
    tick(); tick(); #1;
    checks++;
    if (strobes !== 9'b0) begin
      failures++; $display("FAIL reset_por_strobes: got %b required %b", strobes, 9'b0);
    end
    rst = 1'b0; #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr_sel, bus.ir_we} !== 3'b101) begin
      failures++; $display("FAIL reset_por_fetch: got %b required %b",
                           {bus.mem_req, bus.mem_addr_sel, bus.ir_we}, 3'b101);
    end
    // Drive an LDR into MEM, then reset it there.
    bus.instr = 32'hE591_0008;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0; #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr_sel} !== 2'b11) begin
      failures++; $display("FAIL reset_in_mem: got %b required %b",
                           {bus.mem_req, bus.mem_addr_sel}, 2'b11);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (strobes !== 9'b0) begin
        failures++; $display("FAIL reset_mid_strobes[%0d]: got %b required %b", i, strobes, 9'b0);
      end
      tick();
    end
    rst = 1'b0; #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr_sel, bus.mem_we, bus.reg_we} !== 4'b1000) begin
      failures++; $display("FAIL reset_release_fetch: got %b required %b",
                           {bus.mem_req, bus.mem_addr_sel, bus.mem_we, bus.reg_we}, 4'b1000);
    end
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_add_imm();
    bus.instr = 32'hE281_0005; bus.flags = 4'h0; bus.mem_ready = 1'b1; #1;
    checks++;
    if ({bus.ir_we, bus.pc_we, bus.pc_src, bus.mem_req, bus.mem_addr_sel, bus.retire} !== 7'b1100100) begin
      failures++; $display("FAIL add_fetch: got %b required %b",
        {bus.ir_we, bus.pc_we, bus.pc_src, bus.mem_req, bus.mem_addr_sel, bus.retire}, 7'b1100100);
    end
    tick(); #1;
    checks++;
    if ({bus.ext_op, bus.retire} !== 3'b000) begin
      failures++; $display("FAIL add_decode: got %b required %b", {bus.ext_op, bus.retire}, 3'b000);
    end
    tick(); #1;
    checks++;
    if ({bus.alu_src_b, bus.alu_op, bus.flags_we, bus.reg_we, bus.retire} !== 8'b1_0100_000) begin
      failures++; $display("FAIL add_exec: got %b required %b",
        {bus.alu_src_b, bus.alu_op, bus.flags_we, bus.reg_we, bus.retire}, 8'b1_0100_000);
    end
    tick(); #1;
    checks++;
    if ({bus.reg_we, bus.wb_sel, bus.retire} !== 4'b1001) begin
      failures++; $display("FAIL add_wb: got %b required %b", {bus.reg_we, bus.wb_sel, bus.retire}, 4'b1001);
    end
    tick(); #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr_sel, bus.reg_we} !== 3'b100) begin
      failures++; $display("FAIL add_next_fetch: got %b required %b",
                           {bus.mem_req, bus.mem_addr_sel, bus.reg_we}, 3'b100);
    end
  endtask

  task automatic test_compare();
    bus.instr = 32'hE351_0000; bus.mem_ready = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({bus.alu_src_b, bus.alu_op, bus.flags_we, bus.reg_we, bus.retire} !== 8'b1_1010_101) begin
      failures++; $display("FAIL cmp_exec: got %b required %b",
        {bus.alu_src_b, bus.alu_op, bus.flags_we, bus.reg_we, bus.retire}, 8'b1_1010_101);
    end
    tick(); #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr_sel, bus.reg_we} !== 3'b100) begin
      failures++; $display("FAIL cmp_next_fetch: got %b required %b",
                           {bus.mem_req, bus.mem_addr_sel, bus.reg_we}, 3'b100);
    end
  endtask

  task automatic test_load_wait();
    bus.instr = 32'hE591_0008; bus.mem_ready = 1'b1;
    tick(); #1;
    checks++;
    if (bus.ext_op !== 2'b01) begin
      failures++; $display("FAIL ldr_ext_op: got %b required %b", bus.ext_op, 2'b01);
    end
    tick(); #1;
    checks++;
    if ({bus.alu_src_b, bus.alu_op} !== 5'b1_0100) begin
      failures++; $display("FAIL ldr_addr: got %b required %b", {bus.alu_src_b, bus.alu_op}, 5'b1_0100);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = (i == 2); #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.reg_we, bus.retire} !== 5'b10100) begin
        failures++; $display("FAIL ldr_mem[%0d]: got %b required %b", i,
          {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.reg_we, bus.retire}, 5'b10100);
      end
      tick();
    end
    #1;
    checks++;
    if ({bus.reg_we, bus.wb_sel, bus.retire} !== 4'b1011) begin
      failures++; $display("FAIL ldr_wb: got %b required %b", {bus.reg_we, bus.wb_sel, bus.retire}, 4'b1011);
    end
    tick();
  endtask

  task automatic test_branch();
    logic [31:0] t_instr [7];
    logic [3:0]  t_flags [7];
    logic        t_taken [7];
    logic        t_link  [7];
    t_instr = '{32'h0A00_0010, 32'h0A00_0010, 32'hEB00_0002, 32'hBA00_0000,
                32'hCA00_0000, 32'h2A00_0000, 32'h1A00_0000};
    t_flags = '{4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1100, 4'b0010, 4'b0000};
    t_taken = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t_link  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.instr = t_instr[k]; bus.flags = t_flags[k];
      tick(); #1;
      checks++;
      if ({bus.retire, bus.pc_we, bus.pc_src, bus.ext_op} !== {~t_taken[k], 1'b0, 2'b00, 2'b10}) begin
        failures++; $display("FAIL br_decode[%0d]: got %b required %b", k,
          {bus.retire, bus.pc_we, bus.pc_src, bus.ext_op}, {~t_taken[k], 1'b0, 2'b00, 2'b10});
      end
      if (t_taken[k]) begin
        tick(); #1;
        checks++;
        if ({bus.pc_we, bus.pc_src, bus.reg_we, bus.wb_sel, bus.retire} !==
            {1'b1, 2'b01, t_link[k], (t_link[k] ? 2'b10 : 2'b00), 1'b1}) begin
          failures++; $display("FAIL br_exec[%0d]: got %b required %b", k,
            {bus.pc_we, bus.pc_src, bus.reg_we, bus.wb_sel, bus.retire},
            {1'b1, 2'b01, t_link[k], (t_link[k] ? 2'b10 : 2'b00), 1'b1});
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout(input logic late_ready);
    bus.instr = 32'hE581_0008; bus.flags = 4'h0; bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.bus_err, bus.retire} !== 4'b1100) begin
        failures++; $display("FAIL str_wait[%0d]: got %b required %b", i,
          {bus.mem_req, bus.mem_we, bus.bus_err, bus.retire}, 4'b1100);
      end
      tick();
    end
    bus.mem_ready = late_ready; #1;
    checks++;
    if (late_ready) begin
      if ({bus.bus_err, bus.mem_we, bus.retire} !== 3'b011) begin
        failures++; $display("FAIL str_ready_wins: got %b required %b",
          {bus.bus_err, bus.mem_we, bus.retire}, 3'b011);
      end
    end else begin
      if ({bus.bus_err, bus.mem_we, bus.retire, bus.reg_we, bus.ir_we, bus.pc_we} !== 6'b100000) begin
        failures++; $display("FAIL str_timeout: got %b required %b",
          {bus.bus_err, bus.mem_we, bus.retire, bus.reg_we, bus.ir_we, bus.pc_we}, 6'b100000);
      end
    end
    tick();
    bus.mem_ready = 1'b0; #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr_sel, bus.bus_err} !== 3'b100) begin
      failures++; $display("FAIL str_after_fetch: got %b required %b",
        {bus.mem_req, bus.mem_addr_sel, bus.bus_err}, 3'b100);
    end
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_illegal();
    bus.instr = 32'hEC00_0000; bus.flags = 4'h0; bus.mem_ready = 1'b1;
    tick(); #1;
    checks++;
    if ({bus.illegal, bus.retire, bus.ext_op, bus.reg_we} !== 5'b11110) begin
      failures++; $display("FAIL ill_decode: got %b required %b",
        {bus.illegal, bus.retire, bus.ext_op, bus.reg_we}, 5'b11110);
    end
    tick(); #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr_sel, bus.illegal} !== 3'b100) begin
      failures++; $display("FAIL ill_next_fetch: got %b required %b",
        {bus.mem_req, bus.mem_addr_sel, bus.illegal}, 3'b100);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add_imm();
    test_compare();
    test_load_wait();
    test_branch();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
